// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg
//   Shared types and constants for the fetch/data memory port arbiter.
//   state_t : sequencer states (IDLE -> ACCESS -> RESP).
//   grant_t : which CPU port owns the current access.
//   SX_*    : StoreX access-size encodings as seen by the memory.
//   sx_bytes: number of bytes touched by a given StoreX encoding.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    typedef enum logic {
        GNT_IF = 1'b0,
        GNT_D  = 1'b1
    } grant_t;

    localparam logic [1:0] SX_BYTE = 2'b00;
    localparam logic [1:0] SX_HALF = 2'b01;
    localparam logic [1:0] SX_WORD = 2'b11;

    // The illegal encoding 2'b10 is reported as a word so the range test
    // stays conservative; it is flagged as an error separately.
    function automatic logic [2:0] sx_bytes(input logic [1:0] sx);
        case (sx)
            SX_BYTE: sx_bytes = 3'd1;
            SX_HALF: sx_bytes = 3'd2;
            default: sx_bytes = 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mem_align_check.sv
// mem_align_check
//   Combinational alignment and range check for one memory request.
//   Parameter MEM_BYTES : memory size in bytes.
//   addr     in  32 : request byte address
//   storex   in  2  : access size (ignored for fetches, which are words)
//   is_fetch in  1  : 1 = instruction fetch, 0 = data access
//   err      out 1  : misaligned, illegal size, or past the end of memory
module mem_align_check
    import mem_arb_pkg::*;
#(
    parameter int unsigned MEM_BYTES = 16384
) (
    input  logic [31:0] addr,
    input  logic [1:0]  storex,
    input  logic        is_fetch,
    output logic        err
);

    logic [2:0]  nbytes;
    logic        misalign;
    logic        illegal;
    logic [32:0] end_addr;

    always_comb begin
        nbytes   = 3'd4;
        misalign = 1'b0;
        illegal  = 1'b0;
        if (is_fetch) begin
            misalign = |addr[1:0];
        end else begin
            nbytes = sx_bytes(storex);
            case (storex)
                SX_BYTE: misalign = 1'b0;
                SX_HALF: misalign = addr[0];
                SX_WORD: misalign = |addr[1:0];
                default: illegal  = 1'b1;
            endcase
        end
        // 33-bit sum so addresses near 2^32 cannot wrap back into range.
        end_addr = {1'b0, addr} + {30'd0, nbytes};
        err      = misalign | illegal | (end_addr > 33'(MEM_BYTES));
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one 16 KB byte-addressed memory between the CPU fetch port and
//   data port. Each granted request takes one ACCESS cycle and one RESP
//   cycle; ties are broken round-robin. Only this block drives the memory
//   address/writedata/MemRead/MemWrite/StoreX inputs.
//   clk, rst            : clock, asynchronous active-high reset
//   if_req/if_addr      : fetch request and word address
//   if_ack/if_rdata/if_err : fetch completion pulse, word, error
//   d_req/d_we/d_addr/d_wdata/d_storex : data request, store flag, address,
//                         right-justified store data, access size
//   d_ack/d_rdata/d_err : data completion pulse, full loaded word, error
//   mem_addr/mem_wdata/mem_read/mem_write/mem_storex : to memory
//   mem_rdata           : combinational read data from memory
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned MEM_BYTES = 16384
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_ack,
    output logic [31:0] if_rdata,
    output logic        if_err,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [1:0]  d_storex,
    output logic        d_ack,
    output logic [31:0] d_rdata,
    output logic        d_err,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_read,
    output logic        mem_write,
    output logic [1:0]  mem_storex,
    input  logic [31:0] mem_rdata
);

    state_t      state;
    grant_t      last_grant;
    grant_t      grant;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;
    logic [1:0]  lat_storex;
    logic        lat_we;
    logic        lat_err;
    logic [31:0] rdata_q;
    logic        err_q;

    grant_t      win;
    logic        win_fetch;
    logic [31:0] win_addr;
    logic [1:0]  win_storex;
    logic        win_err;

    // Winner selection: a lone requester wins; on a tie the port that was
    // not granted last wins.
    always_comb begin
        if (if_req && d_req) begin
            win = (last_grant == GNT_D) ? GNT_IF : GNT_D;
        end else if (if_req) begin
            win = GNT_IF;
        end else begin
            win = GNT_D;
        end
        win_fetch  = (win == GNT_IF);
        win_addr   = win_fetch ? if_addr : d_addr;
        win_storex = win_fetch ? SX_WORD : d_storex;
    end

    mem_align_check #(
        .MEM_BYTES (MEM_BYTES)
    ) u_align_check (
        .addr     (win_addr),
        .storex   (win_storex),
        .is_fetch (win_fetch),
        .err      (win_err)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= GNT_D;
            grant      <= GNT_D;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            lat_storex <= SX_WORD;
            lat_we     <= 1'b0;
            lat_err    <= 1'b0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (if_req || d_req) begin
                        grant      <= win;
                        last_grant <= win;
                        lat_addr   <= win_addr;
                        lat_wdata  <= win_fetch ? '0 : d_wdata;
                        lat_storex <= win_storex;
                        lat_we     <= !win_fetch && d_we;
                        lat_err    <= win_err;
                        state      <= ACCESS;
                    end
                end
                ACCESS: begin
                    rdata_q <= lat_err ? '0 : mem_rdata;
                    err_q   <= lat_err;
                    state   <= RESP;
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Acks and response data decode straight from state, so an async reset
    // during ACCESS removes mem_write in the same cycle and no ack follows.
    always_comb begin
        if_ack   = (state == RESP) && (grant == GNT_IF);
        d_ack    = (state == RESP) && (grant == GNT_D);
        if_rdata = if_ack ? rdata_q : '0;
        d_rdata  = d_ack ? rdata_q : '0;
        if_err   = if_ack && err_q;
        d_err    = d_ack && err_q;

        mem_addr   = '0;
        mem_wdata  = '0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_storex = SX_WORD;
        if (state == ACCESS) begin
            mem_addr   = lat_addr;
            mem_wdata  = lat_wdata;
            mem_storex = lat_storex;
            mem_read   = !lat_err;
            mem_write  = !lat_err && lat_we;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
//   Self-checking bench for mem_port_arbiter. Provides a behavioural byte
//   memory on the mem_* side and compares every transaction against a
//   reference model (round-robin order, error rules, byte-array memory).
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    localparam int unsigned MEM_BYTES = 16384;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, d_req, d_we;
    logic [31:0] if_addr, d_addr, d_wdata;
    logic [1:0]  d_storex;
    logic        if_ack, if_err, d_ack, d_err;
    logic [31:0] if_rdata, d_rdata;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_read, mem_write;
    logic [1:0]  mem_storex;

    int n_vec = 0;
    int n_bad = 0;
    bit m_last_d = 1'b1;
    logic [31:0] last_d_rdata;

    logic [7:0] env_mem [MEM_BYTES];
    logic [7:0] ref_mem [MEM_BYTES];
    logic [7:0] rd_byte [4];

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .MEM_BYTES (MEM_BYTES)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .if_req     (if_req),
        .if_addr    (if_addr),
        .if_ack     (if_ack),
        .if_rdata   (if_rdata),
        .if_err     (if_err),
        .d_req      (d_req),
        .d_we       (d_we),
        .d_addr     (d_addr),
        .d_wdata    (d_wdata),
        .d_storex   (d_storex),
        .d_ack      (d_ack),
        .d_rdata    (d_rdata),
        .d_err      (d_err),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_storex (mem_storex),
        .mem_rdata  (mem_rdata)
    );

    // Environment memory: combinational little-endian read, bytes past the
    // end read as zero; writes commit on the rising edge.
    for (genvar k = 0; k < 4; k++) begin : g_rd
        assign rd_byte[k] = (({1'b0, mem_addr} + 33'(k)) < 33'(MEM_BYTES))
                            ? env_mem[mem_addr[13:0] + 14'(k)] : 8'h00;
    end
    assign mem_rdata = {rd_byte[3], rd_byte[2], rd_byte[1], rd_byte[0]};

    always @(posedge clk) begin
        if (mem_write) begin
            env_mem[mem_addr[13:0]] <= mem_wdata[7:0];
            if (mem_storex != SX_BYTE) env_mem[mem_addr[13:0] + 14'd1] <= mem_wdata[15:8];
            if (mem_storex == SX_WORD) begin
                env_mem[mem_addr[13:0] + 14'd2] <= mem_wdata[23:16];
                env_mem[mem_addr[13:0] + 14'd3] <= mem_wdata[31:24];
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_word(input logic [31:0] a);
        logic [31:0] w = '0;
        for (int k = 0; k < 4; k++)
            if (longint'(a) + k < MEM_BYTES) w[8*k +: 8] = ref_mem[int'(a) + k];
        return w;
    endfunction

    function automatic bit ref_err(input bit fetch, input logic [31:0] a, input logic [1:0] sx);
        int size;
        if (fetch) size = 4;
        else if (sx == 2'b10) return 1'b1;
        else size = (sx == 2'b00) ? 1 : (sx == 2'b01) ? 2 : 4;
        if ((longint'(a) % size) != 0) return 1'b1;
        if (longint'(a) + size > MEM_BYTES) return 1'b1;
        return 1'b0;
    endfunction

    task automatic ref_store(input logic [31:0] a, input logic [31:0] wd, input logic [1:0] sx);
        int size = (sx == 2'b00) ? 1 : (sx == 2'b01) ? 2 : 4;
        for (int k = 0; k < size; k++) ref_mem[int'(a) + k] = wd[8*k +: 8];
    endtask

    // One round of requests (either or both ports) run to completion.
    task automatic txn(input bit do_if, input logic [31:0] ia, input bit do_d, input bit we,
                       input logic [31:0] da, input logic [31:0] wd, input logic [1:0] sx);
        int exp_if_cyc, exp_d_cyc, wr_exp;
        int cyc = 0;
        int wr_seen = 0;
        bit if_pend = do_if;
        bit d_pend = do_d;
        bit if_first, first_err, e;
        logic [31:0] first_addr;

        if_first = (do_if && do_d) ? m_last_d : do_if;
        exp_if_cyc = !do_if ? 0 : (if_first ? 2 : 5);
        exp_d_cyc  = !do_d ? 0 : (if_first ? 5 : 2);
        m_last_d   = (do_if && do_d) ? if_first : !do_if;
        first_addr = if_first ? ia : da;
        first_err  = if_first ? ref_err(1'b1, ia, SX_WORD) : ref_err(1'b0, da, sx);
        wr_exp     = (do_d && we && !ref_err(1'b0, da, sx)) ? 1 : 0;

        if_req = do_if; if_addr = ia;
        d_req = do_d; d_we = we; d_addr = da; d_wdata = wd; d_storex = sx;

        while ((if_pend || d_pend) && cyc < 12) begin
            @(posedge clk); @(negedge clk); cyc++;
            if (cyc == 1) begin
                check("access_read", mem_read, !first_err);
                check("access_addr", mem_addr, first_addr);
            end
            if (mem_write) begin
                wr_seen++;
                check("wr_addr", mem_addr, da);
                check("wr_data", mem_wdata, wd);
                check("wr_storex", mem_storex, sx);
            end
            if (if_ack) begin
                e = ref_err(1'b1, ia, SX_WORD);
                check("if_ack_pending", if_pend, 1);
                check("if_ack_cycle", cyc, exp_if_cyc);
                check("if_err", if_err, e);
                check("if_rdata", if_rdata, e ? 32'h0 : ref_word(ia));
                if_pend = 1'b0; if_req = 1'b0;
            end
            if (d_ack) begin
                e = ref_err(1'b0, da, sx);
                check("d_ack_pending", d_pend, 1);
                check("d_ack_cycle", cyc, exp_d_cyc);
                check("d_err", d_err, e);
                check("d_rdata", d_rdata, e ? 32'h0 : ref_word(da));
                last_d_rdata = d_rdata;
                if (!e && we) ref_store(da, wd, sx);
                d_pend = 1'b0; d_req = 1'b0;
            end
        end
        check("ack_timeout", {if_pend, d_pend}, 0);
        @(posedge clk); @(negedge clk);
        if (mem_write) wr_seen++;
        check("ack_width", {if_ack, d_ack}, 0);
        check("wr_count", wr_seen, wr_exp);
    endtask

    function automatic logic [31:0] rand_addr();
        case ($urandom_range(0, 2))
            0:       return 32'($urandom_range(0, 63));
            1:       return 32'(MEM_BYTES - 8 + $urandom_range(0, 11));
            default: return 32'($urandom_range(0, MEM_BYTES - 1));
        endcase
    endfunction

    initial begin
        #500000;
        n_bad++;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        logic [31:0] ia, da;
        bit same;
        logic [7:0] b;

        for (int i = 0; i < MEM_BYTES; i++) begin
            b = 8'($urandom);
            env_mem[i] = b;
            ref_mem[i] = b;
        end
        {env_mem[16'h3003], env_mem[16'h3002], env_mem[16'h3001], env_mem[16'h3000]} = 32'h014a5026;
        {ref_mem[16'h3003], ref_mem[16'h3002], ref_mem[16'h3001], ref_mem[16'h3000]} = 32'h014a5026;

        rst = 1'b1; if_req = 0; d_req = 0; d_we = 0;
        if_addr = '0; d_addr = '0; d_wdata = '0; d_storex = SX_WORD;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_acks", {if_ack, d_ack, if_err, d_err}, 0);
        check("rst_if_rdata", if_rdata, 0);
        check("rst_d_rdata", d_rdata, 0);
        check("rst_mem_ctl", {mem_read, mem_write, mem_storex}, 4'b0011);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        rst = 1'b0;

        // Tie twice: fetch wins first after reset, then alternates.
        txn(1, 32'h3004, 1, 0, 32'h0, 32'h0, SX_WORD);
        txn(1, 32'h3004, 1, 0, 32'h0, 32'h0, SX_WORD);
        // Fetch only.
        txn(1, 32'h3000, 0, 0, 32'h0, 32'h0, SX_WORD);

        txn(0, 0, 1, 1, 32'h10, 32'hdeadbeef, SX_WORD);
        txn(0, 0, 1, 0, 32'h10, 32'h0, SX_WORD);
        check("load_word_value", last_d_rdata, 32'hdeadbeef);
        txn(0, 0, 1, 1, 32'h11, 32'h55, SX_BYTE);
        txn(0, 0, 1, 0, 32'h10, 32'h0, SX_WORD);
        check("load_after_byte", last_d_rdata, 32'hdead55ef);

        // Error cases.
        txn(0, 0, 1, 1, 32'h13, 32'h1234, SX_HALF);
        txn(0, 0, 1, 1, 32'h12, 32'h11223344, SX_WORD);
        txn(0, 0, 1, 1, 32'h20, 32'h99887766, 2'b10);
        txn(0, 0, 1, 0, 32'h20, 32'h0, 2'b10);
        txn(1, 32'h3002, 0, 0, 32'h0, 32'h0, SX_WORD);
        // Upper boundary.
        txn(0, 0, 1, 1, 32'h3ffc, 32'ha5a5c3c3, SX_WORD);
        txn(0, 0, 1, 1, 32'h3ffe, 32'h0badf00d, SX_WORD);
        txn(0, 0, 1, 0, 32'h4000, 32'h0, SX_WORD);
        txn(0, 0, 1, 0, 32'h3ffc, 32'h0, SX_WORD);
        check("top_word_value", last_d_rdata, 32'ha5a5c3c3);

        // Reset in the middle of a store's ACCESS cycle.
        d_req = 1; d_we = 1; d_addr = 32'h40; d_wdata = 32'hcafef00d; d_storex = SX_WORD;
        @(posedge clk); @(negedge clk);
        check("rst_pre_write", mem_write, 1);
        rst = 1'b1;
        #1;
        check("rst_write_drop", mem_write, 0);
        d_req = 0; d_we = 0;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); @(negedge clk);
            check("rst_no_ack", {if_ack, d_ack, mem_read, mem_write}, 0);
        end
        check("rst_mem_intact",
              {env_mem[16'h43], env_mem[16'h42], env_mem[16'h41], env_mem[16'h40]}, ref_word(32'h40));
        m_last_d = 1'b1;
        txn(1, 32'h100, 1, 0, 32'h104, 32'h0, SX_WORD);

        // Randomised mix.
        for (int n = 0; n < 60; n++) begin
            ia = rand_addr();
            if ($urandom_range(0, 3) != 0) ia[1:0] = 2'b00;
            da = rand_addr();
            case ($urandom_range(0, 2))
                0: txn(1, ia, 0, 0, da, $urandom, 2'($urandom));
                1: txn(0, ia, 1, 1'($urandom), da, $urandom, 2'($urandom));
                default: txn(1, ia, 1, 1'($urandom), da, $urandom, 2'($urandom));
            endcase
        end

        same = 1'b1;
        for (int i = 0; i < MEM_BYTES; i++)
            if (env_mem[i] !== ref_mem[i]) same = 1'b0;
        check("mem_image", same, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Sequences and shares the single byte-addressed, 16 KB unified memory between the CPU's instruction-fetch port and data (load/store) port. Each request becomes one memory access cycle followed by one response cycle. Contention between the two ports is resolved round-robin. Alignment and range are checked before any write strobe is driven. It sits between the CPU control/datapath and the memory, and is the only driver of the memory's address, writedata, MemRead, MemWrite and StoreX inputs.

## Interface
- MEM_BYTES, 16384, memory size in bytes; addresses at or above this are out of range.
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- if_req  in  1  fetch request; held high until if_ack.
- if_addr  in  32  fetch byte address; must be word aligned.
- if_ack  out  1  one-cycle completion pulse for a fetch.
- if_rdata  out  32  fetched word; valid while if_ack=1.
- if_err  out  1  fetch misaligned or out of range; valid with if_ack.
- d_req  in  1  data request; held high until d_ack.
- d_we  in  1  1=store, 0=load.
- d_addr  in  32  data byte address.
- d_wdata  in  32  store data, right-justified.
- d_storex  in  2  access size: 00 byte, 01 half, 11 word, 10 illegal.
- d_ack  out  1  one-cycle completion pulse for a data access.
- d_rdata  out  32  loaded word (little-endian, address through address+3); valid with d_ack.
- d_err  out  1  data access rejected; valid with d_ack.
- mem_addr  out  32  to memory address.
- mem_wdata  out  32  to memory writedata.
- mem_read  out  1  to memory MemRead.
- mem_write  out  1  to memory MemWrite.
- mem_storex  out  2  to memory StoreX.
- mem_rdata  in  32  from memory readdata (combinational).

## Operation
- States: IDLE, ACCESS, RESP.
- IDLE: if any req is high, choose a winner, latch its address/wdata/storex/we and its error check, then go to ACCESS. Otherwise stay in IDLE.
- Arbitration:
  - Only one port requesting: that port wins.
  - Both ports requesting: the port not granted last wins.
  - last_grant resets to DATA, so fetch wins the first tie.
  - last_grant updates only on a grant.
- ACCESS: drive mem_addr, mem_wdata and mem_storex from the latched values. mem_read=1 for every non-error access. mem_write=1 only for a non-error store. Capture mem_rdata into the response register at the ending edge, then go to RESP.
- RESP: pulse the winner's ack and present rdata/err, then go to IDLE.
- Error rules:
  - Fetch: addr[1:0]≠0.
  - Data: storex 11 with addr[1:0]≠0; storex 01 with addr[0]≠0; storex 10 on either load or store.
  - Both ports: addr+access_bytes > MEM_BYTES.
  - An errored access still takes ACCESS and RESP. mem_read=mem_write=0 during it, rdata=0, err=1.
- Loads always return the full word. Byte/half extraction belongs to the datapath.
- Outside ACCESS: mem_read=0, mem_write=0, mem_storex=11, mem_addr=0, mem_wdata=0.

## Timing
- Reset values: state=IDLE, last_grant=DATA, all ack/err=0, all rdata=0, all mem_* outputs as in the idle row above. Reset is asynchronous: mem_write drops in the same cycle rst rises.
- Latency: a req sampled high in IDLE at edge N gives ACCESS in cycle N+1 and ack in cycle N+2. Back-to-back throughput is one access per 3 cycles.
- The store commits at the rising edge that ends ACCESS. mem_write is high for exactly one cycle.
- Requester must hold req and its operands stable until ack. Req dropping mid-access is a protocol violation; the block completes the latched access and still pulses ack.
- The losing requester stays pending and is granted in the next IDLE.
- Req still high in the ack cycle is treated as a new request at the following IDLE.
- rst during ACCESS aborts it: no write occurs and no ack is issued.

## Structure
- Package mem_arb_pkg holds:
  - state enum (IDLE, ACCESS, RESP);
  - grant enum (GNT_IF, GNT_D);
  - StoreX constants SX_BYTE=2'b00, SX_HALF=2'b01, SX_WORD=2'b11.
- Sub-module mem_align_check (combinational): inputs addr, storex, is_fetch, MEM_BYTES; output err. Instantiated once, on the muxed winner request.

## Test plan
- Fetch only, if_addr=0x3000, memory word 0x014a5026 → ACCESS with mem_read=1 and mem_addr=0x3000 two... one cycle after sampling; if_ack=1 with if_rdata=0x014a5026 two cycles after sampling; mem_write never high.
- Simultaneous if_req (0x3004) and d_req load 0x0000, twice back-to-back → grant order IF, DATA, IF, DATA; each ack exactly one cycle wide; 3-cycle spacing.
- Store word 0xdeadbeef at 0x0010 with storex=11, then load 0x0010 → one mem_write pulse with mem_storex=11; load returns 0xdeadbeef. Store byte 0x55 at 0x0011 then load 0x0010 → 0xdead55ef.
- Store half at 0x0013; store word at 0x0012; storex=10 at 0x0020; fetch at 0x3002 → each acks with err=1, mem_write stays 0, memory unchanged.
- Store word at 0x3FFC succeeds; store word at 0x3FFE and load at 0x4000 → err=1, no write.
- Assert rst mid-ACCESS of a store → mem_write drops immediately, no ack, target bytes unchanged, state IDLE and last_grant=DATA after release.
